// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor control path.
package k_and_s_pkg;

  // Instruction class decoded from the IR
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  // Control FSM states
  typedef enum logic [2:0] {
    RST_ST = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    BRANCH = 3'd5,
    HALTED = 3'd6
  } ctrl_state_type;

  localparam logic [1:0] ALU_OR  = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_AND = 2'd3;

  // ALU operation for a register-to-register class; MOVE passes A through OR
  function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
    logic [1:0] op;
    case (instr)
      I_ADD:   op = ALU_ADD;
      I_SUB:   op = ALU_SUB;
      I_AND:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ks_branch_cond.sv
// Combinational branch-condition evaluator for the K&S control unit.
// OVF_SIGNED picks which overflow flag BOV/BNOV test.
module ks_branch_cond
  import k_and_s_pkg::*;
#(
  parameter int OVF_SIGNED = 1
) (
  input  decoded_instruction_type instr,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    taken
);

  logic ovf_s;

  assign ovf_s = (OVF_SIGNED != 0) ? signed_overflow : unsigned_overflow;

  // Evaluate the condition of the current branch class against the flags
  always_comb begin
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = ~zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = ~neg_op;
      I_BOV:    taken = ovf_s;
      I_BNOV:   taken = ~ovf_s;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ks_control_fsm.sv
// Multi-cycle control FSM for the K&S processor.
// Optional feature macro: KS_CTRL_OVF_BRANCH_EN -- when defined BOV/BNOV
// are real conditional branches; otherwise they complete as NOP in DECODE.
module ks_control_fsm
  import k_and_s_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int OVF_SIGNED  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    instr_done
);

  localparam logic [3:0] LAST_WAIT = 4'(RAM_LATENCY - 1);

  ctrl_state_type state_r;
  ctrl_state_type next_state_s;
  logic [3:0]     wait_cnt_r;
  logic           last_wait_s;
  logic           taken_s;

  assign last_wait_s = (wait_cnt_r == LAST_WAIT);

  ks_branch_cond #(
    .OVF_SIGNED(OVF_SIGNED)
  ) u_branch_cond (
    .instr             (decoded_instruction),
    .zero_op           (zero_op),
    .neg_op            (neg_op),
    .unsigned_overflow (unsigned_overflow),
    .signed_overflow   (signed_overflow),
    .taken             (taken_s)
  );

  // State register and RAM wait counter (cleared on every state entry)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RST_ST;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        wait_cnt_r <= 4'd0;
      end else if ((state_r == FETCH) || (state_r == MEM)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Next-state selection from the current phase and instruction class
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RST_ST: next_state_s = FETCH;
      FETCH: begin
        if (last_wait_s) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        case (decoded_instruction)
          I_HALT:  next_state_s = HALTED;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: next_state_s = EXEC;
          I_LOAD, I_STORE: next_state_s = MEM;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: next_state_s = BRANCH;
`ifdef KS_CTRL_OVF_BRANCH_EN
          I_BOV, I_BNOV: next_state_s = BRANCH;
`endif
          default: next_state_s = FETCH;
        endcase
      end
      EXEC: next_state_s = FETCH;
      MEM: begin
        // Only a LOAD lingers in MEM for the RAM wait states
        if ((decoded_instruction == I_LOAD) && !last_wait_s) begin
          next_state_s = MEM;
        end else begin
          next_state_s = FETCH;
        end
      end
      BRANCH: next_state_s = FETCH;
      HALTED: next_state_s = HALTED;
      default: next_state_s = RST_ST;
    endcase
  end

  // Strobe decode from the registered state, wait counter and instruction
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    instr_done       = 1'b0;
    case (state_r)
      RST_ST: halt = 1'b0;
      FETCH: begin
        addr_sel = 1'b1;
        if (last_wait_s) begin
          ir_enable = 1'b1;
          pc_enable = 1'b1;
        end else begin
          ir_enable = 1'b0;
          pc_enable = 1'b0;
        end
      end
      // NOP-like classes finish here and return straight to FETCH
      DECODE: instr_done = (next_state_s == FETCH);
      EXEC: begin
        write_reg_enable = 1'b1;
        instr_done       = 1'b1;
        operation        = alu_op_of(decoded_instruction);
        flags_reg_enable = (decoded_instruction != I_MOVE);
      end
      MEM: begin
        if (decoded_instruction == I_STORE) begin
          ram_write_enable = 1'b1;
          instr_done       = 1'b1;
        end else if ((decoded_instruction == I_LOAD) && last_wait_s) begin
          write_reg_enable = 1'b1;
          c_sel            = 1'b1;
          instr_done       = 1'b1;
        end else begin
          instr_done = 1'b0;
        end
      end
      BRANCH: begin
        branch     = taken_s;
        pc_enable  = taken_s;
        instr_done = 1'b1;
      end
      HALTED: halt = 1'b1;
      default: halt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ks_control_fsm.sv
// Self-checking bench for ks_control_fsm: directed test-plan cases plus a
// random instruction stream, compared cycle by cycle against a model that
// expands each instruction into its expected strobe sequence.
module tb_ks_control_fsm;
  import k_and_s_pkg::*;

  localparam int L     = 3;
  localparam int OVF_S = 0;

  // Strobe bits of the packed observation word
  localparam logic [11:0] B_BR = 12'h001;
  localparam logic [11:0] B_PC = 12'h002;
  localparam logic [11:0] B_IR = 12'h004;
  localparam logic [11:0] B_WR = 12'h008;
  localparam logic [11:0] B_AD = 12'h010;
  localparam logic [11:0] B_CS = 12'h020;
  localparam logic [11:0] B_FL = 12'h100;
  localparam logic [11:0] B_WE = 12'h200;
  localparam logic [11:0] B_DN = 12'h400;
  localparam logic [11:0] B_HT = 12'h800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decoded_instruction_type di = I_NOP;
  logic fz = 1'b0, fn = 1'b0, fu = 1'b0, fs = 1'b0;
  logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic flags_reg_enable, ram_write_enable, halt, instr_done;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  ks_control_fsm #(.RAM_LATENCY(L), .OVF_SIGNED(OVF_S)) dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
    .zero_op(fz), .neg_op(fn), .unsigned_overflow(fu), .signed_overflow(fs),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .write_reg_enable(write_reg_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign obs = {halt, instr_done, ram_write_enable, flags_reg_enable, operation,
                c_sel, addr_sel, write_reg_enable, ir_enable, pc_enable, branch};

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%03h expected=%03h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] op_word(input int op);
    logic [11:0] v;
    v = 12'(op) << 6;
    return v;
  endfunction

  // Expand one instruction into its per-cycle expected strobe words
  task automatic build(input decoded_instruction_type i, input logic z, input logic n,
                       input logic u, input logic s);
    bit ovf_en;
    bit ovf;
    bit tk;
`ifdef KS_CTRL_OVF_BRANCH_EN
    ovf_en = 1'b1;
`else
    ovf_en = 1'b0;
`endif
    ovf = (OVF_S != 0) ? s : u;
    exp_q.delete();
    for (int k = 0; k < L; k++) exp_q.push_back((k == L - 1) ? (B_AD | B_IR | B_PC) : B_AD);
    tk = 1'b0;
    case (i)
      I_BRANCH: tk = 1'b1;
      I_BZERO:  tk = z;
      I_BNZERO: tk = !z;
      I_BNEG:   tk = n;
      I_BNNEG:  tk = !n;
      I_BOV:    tk = ovf;
      I_BNOV:   tk = !ovf;
      default:  tk = 1'b0;
    endcase
    case (i)
      I_MOVE: begin exp_q.push_back(12'h000); exp_q.push_back(B_WR | B_DN); end
      I_ADD:  begin exp_q.push_back(12'h000); exp_q.push_back(B_WR | B_DN | B_FL | op_word(1)); end
      I_SUB:  begin exp_q.push_back(12'h000); exp_q.push_back(B_WR | B_DN | B_FL | op_word(2)); end
      I_AND:  begin exp_q.push_back(12'h000); exp_q.push_back(B_WR | B_DN | B_FL | op_word(3)); end
      I_OR:   begin exp_q.push_back(12'h000); exp_q.push_back(B_WR | B_DN | B_FL); end
      I_STORE: begin exp_q.push_back(12'h000); exp_q.push_back(B_WE | B_DN); end
      I_LOAD: begin
        exp_q.push_back(12'h000);
        for (int k = 0; k < L - 1; k++) exp_q.push_back(12'h000);
        exp_q.push_back(B_WR | B_CS | B_DN);
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
        exp_q.push_back(12'h000);
        exp_q.push_back(tk ? (B_BR | B_PC | B_DN) : B_DN);
      end
      I_BOV, I_BNOV: begin
        if (ovf_en) begin
          exp_q.push_back(12'h000);
          exp_q.push_back(tk ? (B_BR | B_PC | B_DN) : B_DN);
        end else begin
          exp_q.push_back(B_DN);
        end
      end
      I_HALT: begin
        exp_q.push_back(12'h000);
        for (int k = 0; k < 20; k++) exp_q.push_back(B_HT);
      end
      default: exp_q.push_back(B_DN);
    endcase
  endtask

  // Called at posedge+1 of the first FETCH cycle; returns at posedge+1 after the last cycle
  task automatic run_instr(input decoded_instruction_type i, input logic z, input logic n,
                           input logic u, input logic s);
    di = i; fz = z; fn = n; fu = u; fs = s;
    build(i, z, n, u, s);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check_val($sformatf("%s_c%0d", i.name(), k), obs, exp_q[k]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_hold", obs, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_st", obs, 12'h000);
    @(posedge clk);
    #1;

    run_instr(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_BZERO, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_BZERO, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(I_BOV, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(I_BNOV, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(I_STORE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_MOVE, 1'b1, 1'b1, 1'b1, 1'b1);
    run_instr(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 80; r++) begin
      run_instr(decoded_instruction_type'(4'($urandom_range(0, 14))),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    run_instr(I_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("halt_reset", obs, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("halt_rst_st", obs, 12'h000);
    @(posedge clk);
    #1;

    // STORE interrupted by reset during its MEM cycle
    di = I_STORE;
    repeat (L + 1) @(posedge clk);
    #1;
    check_val("store_mem", obs, B_WE | B_DN);
    rst_n = 1'b0;
    #1;
    check_val("store_reset", obs, 12'h000);
    @(posedge clk);
    #1;
    check_val("store_reset_hold", obs, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("store_rst_st", obs, 12'h000);
    @(posedge clk);
    #1;
    run_instr(I_OR, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
